// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and constants.
package rv32i_types;

  typedef enum logic [1:0] {
    START,
    FETCH,
    HOLD,
    SQUASH
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Holds one fetched instruction and its PC while the pipeline is stalled.
module fetch_skid_buf
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Capture on load; clear returns the buffer to a NOP so nothing stale lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the I-cache request, absorbs
// memory latency and stalls, and drops words made stale by redirects.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_load,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending_pc;

  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_skid_load;
  logic         w_skid_clear;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pc;

  assign w_redirect_pc = align_pc(redirect_pc);
  assign w_pc_plus4    = r_pc + 32'd4;

  // Word arrived while stalled and is still wanted: park it.
  assign w_skid_load  = (r_state == FETCH) && imem_resp && !redirect_valid && stall;
  // Leaving HOLD either consumes or discards the parked word.
  assign w_skid_clear = (r_state == HOLD) && (redirect_valid || !stall);

  fetch_skid_buf u_skid_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // Fetch FSM with PC and pending-redirect bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= START;
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'h0;
    end else begin
      unique case (r_state)
        START: r_state <= FETCH;
        FETCH: begin
          if (imem_resp) begin
            if (redirect_valid) begin
              r_pc <= w_redirect_pc;
            end else if (!stall) begin
              r_pc <= w_pc_plus4;
            end else begin
              r_state <= HOLD;
            end
          end else if (redirect_valid) begin
            // Request in flight cannot be withdrawn; remember where to go.
            r_pending_pc <= w_redirect_pc;
            r_state      <= SQUASH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= FETCH;
          end else if (!stall) begin
            r_pc    <= w_pc_plus4;
            r_state <= FETCH;
          end
        end
        SQUASH: begin
          if (imem_resp) begin
            r_pc    <= redirect_valid ? w_redirect_pc : r_pending_pc;
            r_state <= FETCH;
          end else if (redirect_valid) begin
            r_pending_pc <= w_redirect_pc;
          end
        end
        default: r_state <= START;
      endcase
    end
  end

  // Memory request and IF/ID presentation.
  always_comb begin
    imem_read    = (r_state == FETCH) || (r_state == SQUASH);
    imem_address = r_pc;
    ifid_load    = !stall;
    ifid_valid   = 1'b0;
    ifid_instr   = NOP_INSTR;
    ifid_pc      = r_pc;
    if (!redirect_valid) begin
      if ((r_state == FETCH) && imem_resp && !stall) begin
        ifid_valid = 1'b1;
        ifid_instr = imem_rdata;
      end else if (r_state == HOLD) begin
        ifid_valid = 1'b1;
        ifid_instr = w_skid_instr;
        ifid_pc    = w_skid_pc;
      end
    end
    ifid_pc_plus4 = ifid_pc + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0060;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam int          NCycles = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_load;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_load      (ifid_load),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  // Model of the instruction stream as seen by IF:
  //   m_on      - first request issued (one idle cycle after reset)
  //   m_addr    - address of the word currently wanted / presented
  //   m_doomed  - the outstanding word will be thrown away, m_target follows
  //   m_parked  - a word was delivered during a stall and is waiting to be taken
  bit          m_on;
  bit          m_doomed;
  bit          m_parked;
  logic [31:0] m_addr;
  logic [31:0] m_target;
  logic [31:0] m_word;
  int          lat_left;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A3C_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on     = 1'b0;
    m_doomed = 1'b0;
    m_parked = 1'b0;
    m_addr   = ResetPc;
    m_target = 32'h0;
    m_word   = Nop;
    lat_left = 0;
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step();
    logic        e_read;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] tgt;
    stall          = ($urandom_range(0, 3) == 0);
    redirect_valid = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else                           redirect_pc = $urandom;
    imem_resp  = imem_read && (lat_left == 0);
    imem_rdata = imem_resp ? mem_word(imem_address) : $urandom;
    #1;
    tgt     = {redirect_pc[31:2], 2'b00};
    e_read  = m_on && !m_parked;
    e_valid = 1'b0;
    e_instr = Nop;
    if (!redirect_valid) begin
      if (m_parked) begin
        e_valid = 1'b1;
        e_instr = m_word;
      end else if (e_read && imem_resp && !m_doomed && !stall) begin
        e_valid = 1'b1;
        e_instr = mem_word(m_addr);
      end
    end
    check_eq("imem_read", 32'(imem_read), 32'(e_read));
    if (e_read) check_eq("imem_address", imem_address, m_addr);
    check_eq("ifid_load", 32'(ifid_load), 32'(!stall));
    check_eq("ifid_valid", 32'(ifid_valid), 32'(e_valid));
    check_eq("ifid_instr", ifid_instr, e_instr);
    check_eq("ifid_pc", ifid_pc, m_addr);
    check_eq("ifid_pc_plus4", ifid_pc_plus4, m_addr + 32'd4);
    // Advance the model across the coming edge.
    if (!m_on) begin
      m_on = 1'b1;
    end else if (m_parked) begin
      if (redirect_valid) begin
        m_parked = 1'b0;
        m_addr   = tgt;
      end else if (!stall) begin
        m_parked = 1'b0;
        m_addr   = m_addr + 32'd4;
      end
    end else if (m_doomed) begin
      if (imem_resp) begin
        m_doomed = 1'b0;
        m_addr   = redirect_valid ? tgt : m_target;
      end else if (redirect_valid) begin
        m_target = tgt;
      end
    end else if (imem_resp) begin
      if (redirect_valid)  m_addr = tgt;
      else if (!stall)     m_addr = m_addr + 32'd4;
      else begin
        m_parked = 1'b1;
        m_word   = mem_word(m_addr);
      end
    end else if (redirect_valid) begin
      m_doomed = 1'b1;
      m_target = tgt;
    end
    // Memory latency bookkeeping for the next request.
    if (imem_read) begin
      if (imem_resp) lat_left = $urandom_range(0, 3);
      else           lat_left--;
    end
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_resp      = 1'b0;
    imem_rdata     = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_imem_read", 32'(imem_read), 32'd0);
    check_eq("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check_eq("rst_ifid_instr", ifid_instr, Nop);
    check_eq("rst_ifid_pc", ifid_pc, ResetPc);
    check_eq("rst_ifid_pc_plus4", ifid_pc_plus4, ResetPc + 32'd4);
    rst = 1'b0;
    for (int c = 0; c < NCycles; c++) begin
      if (c == NCycles / 2) begin
        // Reset mid-run must drop the request immediately.
        while (!imem_read) step();
        rst = 1'b1;
        #1;
        check_eq("midrst_imem_read", 32'(imem_read), 32'd0);
        check_eq("midrst_ifid_pc", ifid_pc, ResetPc);
        check_eq("midrst_ifid_valid", 32'(ifid_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RV32I pipeline. Owns the PC, drives the instruction-memory (I-cache) request, absorbs variable memory latency, and presents one instruction per cycle to the IF/ID register along with `pc` and `pc+4`. It accepts branch/jump redirects from EX and downstream stalls from the hazard unit. It guarantees that IF/ID never loads a stale or squashed instruction.

## Interface
- `RESET_PC`, default 32'h00000060: first fetch address after reset.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_read`  out  1  instruction request; held high with `imem_address` stable until `imem_resp`.
- `imem_address`  out  32  fetch address, always 4-byte aligned.
- `imem_resp`  in  1  response strobe; may arrive in any cycle `imem_read` is high, including the first.
- `imem_rdata`  in  32  instruction word, valid with `imem_resp`.
- `stall`  in  1  pipeline frozen; IF/ID must not advance.
- `redirect_valid`  in  1  single-cycle taken branch/jump from EX; always accepted.
- `redirect_pc`  in  32  redirect target (bits [1:0] ignored, forced 0).
- `ifid_load`  out  1  IF/ID enable; equals `!stall`.
- `ifid_valid`  out  1  presented instruction is real; IF/ID inserts a bubble when 0.
- `ifid_instr`  out  32  instruction; 32'h00000013 (NOP) when `ifid_valid`=0.
- `ifid_pc`, `ifid_pc_plus4`  out  32 each  address of presented instruction and +4 (mod 2^32).

## Operation
- States: START, FETCH, HOLD, SQUASH. Registers: `pc`, `pending_pc`, `skid_instr`.
- START: `imem_read`=0. Go to FETCH next cycle.
- FETCH: `imem_read`=1, `imem_address`=`pc`.
  - On `imem_resp` with `redirect_valid`: drop the word, `pc`<=`redirect_pc`, stay in FETCH.
  - On `imem_resp`, `!stall`: present `imem_rdata` combinationally with `ifid_valid`=1, `pc`<=`pc+4`, stay in FETCH.
  - On `imem_resp`, `stall`: `skid_instr`<=`imem_rdata`, go to HOLD.
  - No resp, `redirect_valid`: `pending_pc`<=`redirect_pc`, go to SQUASH. Address is held.
- HOLD: `imem_read`=0; present `skid_instr`/`pc` with `ifid_valid`=1.
  - `redirect_valid`: discard skid, `ifid_valid`=0, `pc`<=`redirect_pc`, go to FETCH.
  - Else `!stall`: `pc`<=`pc+4`, go to FETCH.
- SQUASH: `imem_read`=1 at the old address; `ifid_valid`=0.
  - A new `redirect_valid` overwrites `pending_pc` (latest wins).
  - On `imem_resp`: discard the word, `pc`<=`pending_pc` (or `redirect_pc` if `redirect_valid` in the same cycle), go to FETCH.
- `ifid_valid`=0 in all cases not listed above, and whenever `redirect_valid`=1.
- PC arithmetic is 32-bit wrapping; 32'hFFFFFFFC+4 = 0.

## Timing
- Reset values: state=START, `pc`=`RESET_PC`, `pending_pc`=0, `skid_instr`=NOP. Outputs: `imem_read`=0, `ifid_valid`=0, `ifid_instr`=NOP, `ifid_pc`=`RESET_PC`, `ifid_pc_plus4`=`RESET_PC+4`.
- Latency: an instruction is presented in the same cycle as its `imem_resp` (or from HOLD). With one-cycle hits, throughput is one instruction per cycle.
- After a redirect, the first target instruction is presented no earlier than one cycle after redirect acceptance.
- Reset asserted mid-request abandons the request immediately (`imem_read`=0 asynchronously). The memory side is reset by the same `rst`.
- `imem_address` never changes while `imem_read`=1 and `imem_resp`=0.

## Structure
- Add `fetch_state_t` (START/FETCH/HOLD/SQUASH) and the `NOP_INSTR` = 32'h00000013 constant to the shared `rv32i_types` package.
- One sub-module: `fetch_skid_buf`, holding the instruction/PC buffer with load/clear. The FSM and PC logic stay in `fetch_unit`.

## Test plan
- Reset, then `imem_resp`=1 every cycle after `imem_read` -> `imem_address` 0x60, 0x64, 0x68. `ifid_pc` matches, `ifid_pc_plus4`=`ifid_pc`+4.
- Resp latency 3 cycles -> `imem_address` stable at 0x60 for 3 cycles, `ifid_valid`=1 only in the resp cycle.
- `stall` high for 2 cycles during resp of 0x64 -> HOLD presents the 0x64 word both cycles. On release, the next fetch is 0x68 and there is no duplicate or lost instruction.
- `redirect_valid` with `redirect_pc`=0x200 two cycles into a 4-cycle miss at 0x70 -> address held at 0x70 until resp, that word is dropped (`ifid_valid`=0), next address is 0x200.
- Two redirects (0x300, then 0x400) during SQUASH -> fetch resumes at 0x400.
- Redirect in the same cycle as resp with `stall`=1 -> word dropped, no HOLD entered, next address = `redirect_pc`.
